hline_motion_ctrl: RTL and testbench
====================================

HLINE_MOTION_CTRL -- requirements
Module: hline_motion_ctrl

Interface
REQ-001 Parameter Y_MIN, default 18: top travel limit (lowest Y value).
REQ-002 Parameter Y_MAX, default 630: bottom travel limit (highest Y value).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clk  in  1: rising-edge system clock.
REQ-005 Port reset  in  1: synchronous, active-low reset.
REQ-006 Port frame  in  1: one-cycle pulse per video frame.
REQ-007 Port go  in  1: level; start request from IDLE.
REQ-008 Port hold  in  1: level; freeze motion while high.
REQ-009 Port speed  in  2: steps per frame = 1 << speed, so 1, 2, 4 or 8.
REQ-010 Port start_y  in  16: requested initial Y position.
REQ-011 Port Ycoordinate  in  16: current position from the downstream up/down line counter.
REQ-012 Port YcoordinateUTC  in  1: counter is at Y_MAX.
REQ-013 Port DTC  in  1: counter is at Y_MIN.
REQ-014 Port UP  out  1: increment request to the counter, one cycle per step.
REQ-015 Port DW  out  1: decrement request to the counter, one cycle per step.
REQ-016 Port LD  out  1: load strobe to the counter.
REQ-017 Port ld_val  out  16: load value, driving the counter's sw input.
REQ-018 Port dir  out  1: direction; 1 = increasing Y, 0 = decreasing Y.
REQ-019 Port moving  out  1: high while in STEP or SETTLE.
REQ-020 Port bounce  out  1: one-cycle pulse on each direction reversal.

Function
REQ-021 The FSM SHALL have exactly these states: IDLE, LOAD, LSETTLE, WAIT_FRAME, STEP, SETTLE.
REQ-022 In IDLE with go=1, the next state SHALL be LOAD.
REQ-023 In LOAD, LD=1 for exactly one cycle, with ld_val = start_y clamped to [Y_MIN, Y_MAX] (unsigned compare); the next state SHALL be LSETTLE.
REQ-024 LSETTLE SHALL last one cycle, then go to WAIT_FRAME.
REQ-025 In WAIT_FRAME with frame=1 and hold=0, the block SHALL latch remaining = 1 << speed (4-bit register) and go to STEP.
REQ-026 frame SHALL be ignored in every state other than WAIT_FRAME, and in WAIT_FRAME whenever hold=1.
REQ-027 In STEP with dir=1: if YcoordinateUTC=1 or Ycoordinate >= Y_MAX, the block SHALL assert no UP, clear dir to 0, pulse bounce, and go to SETTLE; otherwise it SHALL assert UP for one cycle, decrement remaining, and go to SETTLE.
REQ-028 In STEP with dir=0: the mirror of REQ-027, using DTC or Ycoordinate <= Y_MIN, DW, and setting dir to 1.
REQ-029 A step that hits a limit SHALL consume one count of remaining, and the reversed direction SHALL take effect from the next step.
REQ-030 SETTLE SHALL last one cycle so the counter output updates; the next state SHALL be STEP if remaining != 0, else WAIT_FRAME.
REQ-031 Each step SHALL therefore take 2 cycles; a frame at speed 3 SHALL complete in 16 cycles after the frame pulse.
REQ-032 UP and DW SHALL never be high in the same cycle, and neither SHALL be high in the same cycle as LD.
REQ-033 hold rising during STEP/SETTLE SHALL NOT abort the current frame's steps; it SHALL take effect at the next WAIT_FRAME.
REQ-034 go=0 SHALL NOT stop motion once it has started; only reset returns the block to IDLE.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 On reset=0 at a clock edge: state=IDLE, UP=0, DW=0, LD=0, ld_val=0, dir=1, moving=0, bounce=0, remaining=0.
REQ-037 Reset mid-STEP SHALL drop UP/DW in the same edge, with no further pulses.
REQ-038 After reset the block SHALL remain in IDLE until go=1.

Verification
REQ-039 Load: go=1, start_y=100 -> LD pulse with ld_val=100; start_y=5 -> ld_val=18; start_y=900 -> ld_val=630.
REQ-040 Speed: Y=100, dir=1, speed=2, one frame pulse -> exactly 4 UP pulses, each 2 cycles apart; Y=104; back in WAIT_FRAME.
REQ-041 Bottom bounce: Y=628, dir=1, speed=2 -> UP, UP (Y=630), limit step with bounce=1 and dir=0, then DW -> Y=629.
REQ-042 Top bounce: Y=19, dir=0, speed=1 -> DW (Y=18), then bounce with dir=1; Y never below 18.
REQ-043 Hold/ignore: hold=1 with 3 frame pulses -> no UP/DW; a frame pulse during STEP -> no extra steps.
REQ-044 Reset: reset=0 during the 3rd step -> the next cycle UP=DW=0, dir=1, state IDLE, no LD until go.

Source files
------------

// File: rtl/hline_motion_ctrl.sv
// Vertical motion controller for a horizontal line sprite: loads a start row, then
// issues UP/DW step requests to an external line counter once per frame and bounces at the limits.
`timescale 1ns/1ps
module hline_motion_ctrl #(
  parameter logic [15:0] Y_MIN = 16'd18,
  parameter logic [15:0] Y_MAX = 16'd630
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame,
  input  logic        go,
  input  logic        hold,
  input  logic [1:0]  speed,
  input  logic [15:0] start_y,
  input  logic [15:0] Ycoordinate,
  input  logic        YcoordinateUTC,
  input  logic        DTC,
  output logic        UP,
  output logic        DW,
  output logic        LD,
  output logic [15:0] ld_val,
  output logic        dir,
  output logic        moving,
  output logic        bounce
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LSETTLE,
    WAIT_FRAME,
    STEP,
    SETTLE
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  remaining, remaining_nx;
  logic [15:0] clamped, ld_val_nx;
  logic        up_nx, dw_nx, ld_nx, dir_nx, moving_nx, bounce_nx;
  logic        at_max, at_min;

  always_comb begin
    clamped = start_y;
    if (start_y < Y_MIN)
      clamped = Y_MIN;
    else if (start_y > Y_MAX)
      clamped = Y_MAX;
  end

  // The counter flags and a direct compare are both honoured, whichever trips first.
  assign at_max = YcoordinateUTC || (Ycoordinate >= Y_MAX);
  assign at_min = DTC || (Ycoordinate <= Y_MIN);

  // Outputs are computed for the state being entered and registered below,
  // so a step decided in STEP is seen by the counter during SETTLE.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    ld_val_nx    = ld_val;
    dir_nx       = dir;
    up_nx        = 1'b0;
    dw_nx        = 1'b0;
    ld_nx        = 1'b0;
    bounce_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nx  = LOAD;
          ld_nx     = 1'b1;
          ld_val_nx = clamped;
        end
      end
      LOAD:    state_nx = LSETTLE;
      LSETTLE: state_nx = WAIT_FRAME;
      WAIT_FRAME: begin
        if (frame && !hold) begin
          remaining_nx = 4'd1 << speed;
          state_nx     = STEP;
        end
      end
      STEP: begin
        remaining_nx = remaining - 4'd1;
        state_nx     = SETTLE;
        if (dir) begin
          if (at_max) begin
            dir_nx    = 1'b0;
            bounce_nx = 1'b1;
          end else begin
            up_nx = 1'b1;
          end
        end else begin
          if (at_min) begin
            dir_nx    = 1'b1;
            bounce_nx = 1'b1;
          end else begin
            dw_nx = 1'b1;
          end
        end
      end
      SETTLE: state_nx = (remaining != 4'd0) ? STEP : WAIT_FRAME;
      default: state_nx = IDLE;
    endcase
    moving_nx = (state_nx == STEP) || (state_nx == SETTLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= 4'd0;
      UP        <= 1'b0;
      DW        <= 1'b0;
      LD        <= 1'b0;
      ld_val    <= 16'd0;
      dir       <= 1'b1;
      moving    <= 1'b0;
      bounce    <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      UP        <= up_nx;
      DW        <= dw_nx;
      LD        <= ld_nx;
      ld_val    <= ld_val_nx;
      dir       <= dir_nx;
      moving    <= moving_nx;
      bounce    <= bounce_nx;
    end
  end

endmodule

// File: tb/tb_hline_motion_ctrl.sv
// Bench for hline_motion_ctrl: a saturating line-counter model feeds Y back, and a queue of
// predicted step/bounce events is compared against the pulses the DUT produces.
`timescale 1ns/1ps
module tb_hline_motion_ctrl;

  localparam logic [15:0] YMIN = 16'd18;
  localparam logic [15:0] YMAX = 16'd630;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame = 1'b0;
  logic        go = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic [15:0] start_y = 16'd0;
  logic [15:0] ycnt = 16'd0;
  logic        utc, dtc;
  logic        UP, DW, LD, dir, moving, bounce;
  logic [15:0] ld_val;

  logic        yset = 1'b0;
  logic [15:0] yset_val = 16'd0;
  logic        up_at_max = 1'b0;
  logic        dw_at_min = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   cyc;
    logic up;
    logic dw;
    logic bnc;
    logic dir;
  } ev_t;
  ev_t exq[$];

  logic [15:0] m_y;
  logic        m_dir;

  always #5 clk = ~clk;

  assign utc = (ycnt == YMAX);
  assign dtc = (ycnt == YMIN);

  hline_motion_ctrl #(.Y_MIN(YMIN), .Y_MAX(YMAX)) dut (
    .clk(clk), .reset(reset), .frame(frame), .go(go), .hold(hold), .speed(speed),
    .start_y(start_y), .Ycoordinate(ycnt), .YcoordinateUTC(utc), .DTC(dtc),
    .UP(UP), .DW(DW), .LD(LD), .ld_val(ld_val), .dir(dir), .moving(moving), .bounce(bounce)
  );

  // Downstream up/down line counter; flags record any request that would push past a limit.
  always @(posedge clk) begin
    if (yset) ycnt <= yset_val;
    else if (LD) ycnt <= ld_val;
    else if (UP && ycnt != YMAX) ycnt <= ycnt + 16'd1;
    else if (DW && ycnt != YMIN) ycnt <= ycnt - 16'd1;
    if (UP && ycnt >= YMAX) up_at_max <= 1'b1;
    if (DW && ycnt <= YMIN) dw_at_min <= 1'b1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic predict(input logic [1:0] spd);
    ev_t e;
    for (int i = 0; i < (1 << spd); i++) begin
      e.cyc = 2 * i + 2;
      e.up = 1'b0; e.dw = 1'b0; e.bnc = 1'b0;
      if (m_dir) begin
        if (m_y >= YMAX) begin m_dir = 1'b0; e.bnc = 1'b1; end
        else begin e.up = 1'b1; m_y = m_y + 16'd1; end
      end else begin
        if (m_y <= YMIN) begin m_dir = 1'b1; e.bnc = 1'b1; end
        else begin e.dw = 1'b1; m_y = m_y - 16'd1; end
      end
      e.dir = m_dir;
      exq.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; go = 1'b0; frame = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_dir = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input logic pulse_frame, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame = pulse_frame && (i % 3 == 0);
      if (UP || DW || LD || moving) pulses++;
    end
    frame = 1'b0;
  endtask

  task automatic set_y(input logic [15:0] v);
    @(negedge clk);
    yset = 1'b1; yset_val = v;
    @(negedge clk);
    yset = 1'b0;
    m_y = v;
  endtask

  task automatic do_load(input logic [15:0] sy, input logic [15:0] exp, input string name);
    start_y = sy;
    go = 1'b1;
    for (int i = 0; i < 5 && !LD; i++) @(negedge clk);
    go = 1'b0;
    checks++;
    if (LD !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_ld: LD got %b expected 1", name, LD);
    end
    checks++;
    if (ld_val !== exp) begin
      errors++;
      $display("[TB] FAIL %s_val: ld_val got %0d expected %0d", name, ld_val, exp);
    end
    @(negedge clk);
    checks++;
    if (LD !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_width: LD got %b expected 0 one cycle later", name, LD);
    end
    @(negedge clk);
    m_y = exp;
  endtask

  // Drives one frame, optionally pulsing frame again or raising hold mid-motion.
  task automatic run_frame(input logic [1:0] spd, input int xframe_at, input int hold_at,
                           input string name);
    ev_t e;
    int  n;
    logic exp_mov;
    n = 1 << spd;
    predict(spd);
    speed = spd;
    @(negedge clk); frame = 1'b1;
    @(negedge clk); frame = 1'b0;
    for (int c = 1; c <= 2 * n + 2; c++) begin
      if (c > 1) @(negedge clk);
      frame = 1'b0;
      checks++;
      if ((UP && DW) || ((UP || DW) && LD)) begin
        errors++;
        $display("[TB] FAIL %s_excl: UP=%b DW=%b LD=%b at cycle %0d expected exclusive", name, UP, DW, LD, c);
      end
      exp_mov = (c <= 2 * n);
      checks++;
      if (moving !== exp_mov) begin
        errors++;
        $display("[TB] FAIL %s_moving: got %b expected %b at cycle %0d", name, moving, exp_mov, c);
      end
      if (UP || DW || bounce) begin
        checks++;
        if (exq.size() == 0) begin
          errors++;
          $display("[TB] FAIL %s_extra: pulse UP=%b DW=%b bounce=%b at cycle %0d expected none", name, UP, DW, bounce, c);
        end else begin
          e = exq.pop_front();
          if (c !== e.cyc || UP !== e.up || DW !== e.dw || bounce !== e.bnc || dir !== e.dir) begin
            errors++;
            $display("[TB] FAIL %s_event: got cyc=%0d UP=%b DW=%b bounce=%b dir=%b expected cyc=%0d UP=%b DW=%b bounce=%b dir=%b",
                     name, c, UP, DW, bounce, dir, e.cyc, e.up, e.dw, e.bnc, e.dir);
          end
        end
      end
      if (c == xframe_at) frame = 1'b1;
      if (c == hold_at) hold = 1'b1;
    end
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_missing: %0d events outstanding expected 0", name, exq.size());
    end
    exq.delete();
    checks++;
    if (ycnt !== m_y || dir !== m_dir) begin
      errors++;
      $display("[TB] FAIL %s_final: Y=%0d dir=%b expected Y=%0d dir=%b", name, ycnt, dir, m_y, m_dir);
    end
  endtask

  task automatic test_reset();
    int p;
    do_reset();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({UP, DW, LD, dir, moving, bounce} !== 6'b000100 || ld_val !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_vals: UP=%b DW=%b LD=%b dir=%b moving=%b bounce=%b ld_val=%0d expected 0 0 0 1 0 0 0",
               UP, DW, LD, dir, moving, bounce, ld_val);
    end
    reset = 1'b1;
    idle_cycles(12, 1'b1, p);
    checks++;
    if (p != 0) begin
      errors++;
      $display("[TB] FAIL reset_idle: %0d active cycles without go expected 0", p);
    end
  endtask

  task automatic test_load();
    logic [15:0] sy [7] = '{16'd100, 16'd5, 16'd900, 16'd18, 16'd630, 16'd17, 16'd631};
    logic [15:0] ex [7] = '{16'd100, 16'd18, 16'd630, 16'd18, 16'd630, 16'd18, 16'd630};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      do_load(sy[i], ex[i], $sformatf("load%0d", i));
    end
  endtask

  task automatic test_speed();
    do_reset();
    do_load(16'd100, 16'd100, "speed_load");
    run_frame(2'd2, 0, 0, "speed2");
    checks++;
    if (ycnt !== 16'd104) begin
      errors++;
      $display("[TB] FAIL speed2_y: got %0d expected 104", ycnt);
    end
    run_frame(2'd0, 0, 0, "speed0");
    run_frame(2'd3, 0, 0, "speed3");
    checks++;
    if (ycnt !== 16'd113) begin
      errors++;
      $display("[TB] FAIL speed3_y: got %0d expected 113", ycnt);
    end
  endtask

  task automatic test_hold();
    int p;
    hold = 1'b1;
    idle_cycles(12, 1'b1, p);
    checks++;
    if (p != 0) begin
      errors++;
      $display("[TB] FAIL hold_frames: %0d active cycles expected 0", p);
    end
    hold = 1'b0;
    run_frame(2'd1, 3, 0, "frame_in_step");
    run_frame(2'd2, 0, 2, "hold_mid");
    idle_cycles(9, 1'b1, p);
    checks++;
    if (p != 0) begin
      errors++;
      $display("[TB] FAIL hold_next: %0d active cycles expected 0", p);
    end
    hold = 1'b0;
  endtask

  task automatic test_bounce();
    set_y(16'd628);
    run_frame(2'd2, 0, 0, "bottom");
    checks++;
    if (ycnt !== 16'd629 || dir !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bottom_end: Y=%0d dir=%b expected Y=629 dir=0", ycnt, dir);
    end
    set_y(16'd19);
    run_frame(2'd1, 0, 0, "top");
    checks++;
    if (ycnt !== 16'd18 || dir !== 1'b1) begin
      errors++;
      $display("[TB] FAIL top_end: Y=%0d dir=%b expected Y=18 dir=1", ycnt, dir);
    end
    set_y(16'd629);
    run_frame(2'd1, 0, 0, "bottom2");
    checks++;
    if (up_at_max !== 1'b0 || dw_at_min !== 1'b0) begin
      errors++;
      $display("[TB] FAIL limits: up_at_max=%b dw_at_min=%b expected 0 0", up_at_max, dw_at_min);
    end
  endtask

  task automatic test_reset_mid();
    int seen, p;
    logic hit;
    seen = 0; hit = 1'b0;
    speed = 2'd2;
    @(negedge clk); frame = 1'b1;
    @(negedge clk); frame = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (UP || DW) seen++;
      if (seen == 3) begin
        hit = 1'b1;
        reset = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL resetmid_steps: saw %0d steps expected 3", seen);
    end
    checks++;
    if ({UP, DW, LD, moving, bounce, dir} !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL resetmid_vals: UP=%b DW=%b LD=%b moving=%b bounce=%b dir=%b expected 0 0 0 0 0 1",
               UP, DW, LD, moving, bounce, dir);
    end
    reset = 1'b1;
    idle_cycles(10, 1'b1, p);
    checks++;
    if (p != 0) begin
      errors++;
      $display("[TB] FAIL resetmid_idle: %0d active cycles expected 0", p);
    end
    m_dir = 1'b1;
    do_load(16'd300, 16'd300, "resetmid_reload");
  endtask

  initial begin
    $display("[TB] starting hline_motion_ctrl bench");
    test_reset();
    test_load();
    test_speed();
    test_hold();
    test_bounce();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
